// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master round-robin arbiter in front of the single-outstanding
// SoC MMIO port. Master 0 is the host bridge, master 1 is the program/data loader.
// One transaction in flight; the response goes back to the granted master only.
// Optional watchdog: define MMIO_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES limit.
module mmio_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    // host-side masters
    input  logic [1:0]          m_req_val,
    output logic [1:0]          m_req_rdy,
    input  logic [1:0]          m_req_cmd,
    input  logic [2*ADDR_W-1:0] m_req_addr,
    input  logic [2*DATA_W-1:0] m_req_data,
    output logic [1:0]          m_resp_val,
    input  logic [1:0]          m_resp_rdy,
    output logic                m_resp_cmd,
    output logic [ADDR_W-1:0]   m_resp_addr,
    output logic [DATA_W-1:0]   m_resp_data,
    // downstream MMIO port
    output logic                s_req_val,
    input  logic                s_req_rdy,
    output logic                s_req_cmd,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic [DATA_W-1:0]   s_req_data,
    input  logic                s_resp_val,
    output logic                s_resp_rdy,
    input  logic                s_resp_cmd,
    input  logic [ADDR_W-1:0]   s_resp_addr,
    input  logic [DATA_W-1:0]   s_resp_data,
    // status
    output logic                busy,
    output logic                grant_id,
    output logic                timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RETURN} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q;
    logic                grant_id_q;
    logic                req_cmd_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_data_q;
    logic                resp_cmd_q;
    logic [ADDR_W-1:0]   resp_addr_q;
    logic [DATA_W-1:0]   resp_data_q;

    logic                winner;
    logic                req_fire;
    logic                resp_fire;
    logic                resp_done;
    logic                timeout_hit;

    // Round-robin pick: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        // NOTE: give every comb output a default first so no path can infer a latch.
        winner = 1'b0;
        if (m_req_val == 2'b11) begin
            winner = ~last_grant_q;
        end else if (m_req_val == 2'b10) begin
            winner = 1'b1;
        end
    end

    assign req_fire  = (state_q == ST_IDLE) && m_req_val[winner];
    assign resp_fire = (state_q == ST_WAIT) && s_resp_val;
    assign resp_done = (state_q == ST_RETURN) && m_resp_rdy[grant_id_q];

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;
    logic             cnt_expired;

    // A real handshake in the expiry cycle wins over the watchdog.
    assign cnt_expired = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_hit = cnt_expired &&
                         (((state_q == ST_ISSUE) && !s_req_rdy) ||
                          ((state_q == ST_WAIT)  && !s_resp_val));

    // Watchdog count: zero on entering ISSUE, +1 for every cycle in ISSUE or WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (req_fire) begin
            cnt_d = '0;
        end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Watchdog registers; the timeout flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    // Without the watchdog the limit is meaningless; fold it away.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state is always updated with <= so all flops sample together.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_fire) state_d = ST_ISSUE;
            ST_ISSUE:  if (s_req_rdy) state_d = ST_WAIT;
                       else if (timeout_hit) state_d = ST_RETURN;
            ST_WAIT:   if (resp_fire || timeout_hit) state_d = ST_RETURN;
            ST_RETURN: if (resp_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        m_req_rdy  = 2'b00;
        m_resp_val = 2'b00;
        s_req_val  = 1'b0;
        s_resp_rdy = 1'b0;
        case (state_q)
            ST_IDLE:   if (|m_req_val) m_req_rdy = winner ? 2'b10 : 2'b01;
            ST_ISSUE:  s_req_val = 1'b1;
            ST_WAIT:   s_resp_rdy = 1'b1;
            ST_RETURN: m_resp_val = grant_id_q ? 2'b10 : 2'b01;
            default:   ;
        endcase
    end

    // Latched request/response fields and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these few registers are cheap to reset and the reset value is visible on ports, so they clear.
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            req_cmd_q    <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            resp_cmd_q   <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            if (req_fire) begin
                grant_id_q <= winner;
                req_cmd_q  <= m_req_cmd[winner];
                req_addr_q <= winner ? m_req_addr[ADDR_W +: ADDR_W] : m_req_addr[0 +: ADDR_W];
                req_data_q <= winner ? m_req_data[DATA_W +: DATA_W] : m_req_data[0 +: DATA_W];
            end
            if (resp_fire) begin
                resp_cmd_q  <= s_resp_cmd;
                resp_addr_q <= s_resp_addr;
                resp_data_q <= s_resp_data;
            end else if (timeout_hit) begin
                resp_cmd_q  <= req_cmd_q;
                resp_addr_q <= req_addr_q;
                resp_data_q <= '1;
            end
            if (resp_done) begin
                last_grant_q <= grant_id_q;
            end
        end
    end

    assign s_req_cmd   = req_cmd_q;
    assign s_req_addr  = req_addr_q;
    assign s_req_data  = req_data_q;
    assign m_resp_cmd  = resp_cmd_q;
    assign m_resp_addr = resp_addr_q;
    assign m_resp_data = resp_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: a table of single transactions with hand-computed
// grants and fields, plus hand sequences for backpressure, reset mid-WAIT and the watchdog.
module tb_mmio_arbiter;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic         clk;
    logic         rst_n;
    logic [1:0]   m_req_val;
    logic [1:0]   m_req_rdy;
    logic [1:0]   m_req_cmd;
    logic [63:0]  m_req_addr;
    logic [127:0] m_req_data;
    logic [1:0]   m_resp_val;
    logic [1:0]   m_resp_rdy;
    logic         m_resp_cmd;
    logic [31:0]  m_resp_addr;
    logic [63:0]  m_resp_data;
    logic         s_req_val;
    logic         s_req_rdy;
    logic         s_req_cmd;
    logic [31:0]  s_req_addr;
    logic [63:0]  s_req_data;
    logic         s_resp_val;
    logic         s_resp_rdy;
    logic         s_resp_cmd;
    logic [31:0]  s_resp_addr;
    logic [63:0]  s_resp_data;
    logic         busy;
    logic         grant_id;
    logic         timeout_o;

    mmio_arbiter #(
        .ADDR_W(32),
        .DATA_W(64),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_val(m_req_val), .m_req_rdy(m_req_rdy), .m_req_cmd(m_req_cmd),
        .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_resp_val(m_resp_val), .m_resp_rdy(m_resp_rdy), .m_resp_cmd(m_resp_cmd),
        .m_resp_addr(m_resp_addr), .m_resp_data(m_resp_data),
        .s_req_val(s_req_val), .s_req_rdy(s_req_rdy), .s_req_cmd(s_req_cmd),
        .s_req_addr(s_req_addr), .s_req_data(s_req_data),
        .s_resp_val(s_resp_val), .s_resp_rdy(s_resp_rdy), .s_resp_cmd(s_resp_cmd),
        .s_resp_addr(s_resp_addr), .s_resp_data(s_resp_data),
        .busy(busy), .grant_id(grant_id), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total  = 0;
    int n_passed = 0;
    int s_fires  = 0;

    // Count downstream request handshakes.
    always @(posedge clk) begin
        if (rst_n && s_req_val && s_req_rdy) s_fires++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0]  val;
        logic [1:0]  cmd;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [63:0] data0;
        logic [63:0] data1;
        logic [63:0] rdata;
        logic        exp_grant;
        logic        exp_cmd;
        logic [31:0] exp_addr;
        logic [63:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] val, input logic [1:0] cmd,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [63:0] rd, input logic g, input logic ec,
                                input logic [31:0] ea, input logic [63:0] ew);
        vec_t v;
        v.val = val; v.cmd = cmd; v.addr0 = a0; v.addr1 = a1; v.data0 = d0; v.data1 = d1;
        v.rdata = rd; v.exp_grant = g; v.exp_cmd = ec; v.exp_addr = ea; v.exp_wdata = ew;
        return v;
    endfunction

    // One zero-wait transaction: handshake, issue, response, return, back to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0] onehot;
        onehot = v.exp_grant ? 2'b10 : 2'b01;
        @(negedge clk);
        m_req_val  = v.val;
        m_req_cmd  = v.cmd;
        m_req_addr = {v.addr1, v.addr0};
        m_req_data = {v.data1, v.data0};
        s_req_rdy  = 1'b1;
        m_resp_rdy = 2'b11;
        #1;
        check({tag, "_req_rdy"}, 64'(m_req_rdy), 64'(onehot));
        @(negedge clk);
        m_req_val = 2'b00;
        check({tag, "_grant"}, 64'(grant_id), 64'(v.exp_grant));
        check({tag, "_s_req_val"}, 64'(s_req_val), 64'd1);
        check({tag, "_s_req_cmd"}, 64'(s_req_cmd), 64'(v.exp_cmd));
        check({tag, "_s_req_addr"}, 64'(s_req_addr), 64'(v.exp_addr));
        check({tag, "_s_req_data"}, s_req_data, v.exp_wdata);
        @(negedge clk);
        check({tag, "_s_resp_rdy"}, 64'(s_resp_rdy), 64'd1);
        s_resp_val  = 1'b1;
        s_resp_cmd  = v.exp_cmd;
        s_resp_addr = v.exp_addr;
        s_resp_data = v.rdata;
        @(negedge clk);
        s_resp_val = 1'b0;
        check({tag, "_m_resp_val"}, 64'(m_resp_val), 64'(onehot));
        check({tag, "_m_resp_cmd"}, 64'(m_resp_cmd), 64'(v.exp_cmd));
        check({tag, "_m_resp_addr"}, 64'(m_resp_addr), 64'(v.exp_addr));
        check({tag, "_m_resp_data"}, m_resp_data, v.rdata);
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_resp_val"}, 64'(m_resp_val), 64'd0);
    endtask

    vec_t vecs[11];

    initial begin
        // Table: after reset last_grant = 1, so the first tie goes to master 0.
        vecs[0] = mk(2'b11, 2'b01, 32'h4000_0000, 32'h0000_0004, 64'hDEAD_BEEF_0000_0001,
                     64'h0000_0000_0000_5555, 64'h0000_0000_0000_00AA,
                     1'b0, 1'b1, 32'h4000_0000, 64'hDEAD_BEEF_0000_0001);
        vecs[1] = mk(2'b10, 2'b00, 32'h0, 32'h0000_0004, 64'h0, 64'h0000_0000_0000_5555,
                     64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 32'h0000_0004, 64'h0000_0000_0000_5555);
        vecs[2] = mk(2'b01, 2'b00, 32'h8000_0010, 32'h0, 64'h0, 64'h0,
                     64'h1122_3344_5566_7788, 1'b0, 1'b0, 32'h8000_0010, 64'h0);
        vecs[3] = mk(2'b10, 2'b10, 32'h0, 32'h3000_0008, 64'h0, 64'hCAFE_F00D_1234_5678,
                     64'h0000_0000_0000_0077, 1'b1, 1'b1, 32'h3000_0008, 64'hCAFE_F00D_1234_5678);
        // Continuous contention: master 1 was served last, so grants run 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a0, a1;
            logic [63:0] d0, d1;
            a0 = 32'h1000_0000 + 32'(k * 16);
            a1 = 32'h2000_0004 + 32'(k * 16);
            d0 = 64'hA0A0_A0A0_0000_0000 + 64'(k);
            d1 = 64'hB0B0_B0B0_0000_0000 + 64'(k);
            if (k % 2 == 0)
                vecs[4+k] = mk(2'b11, 2'b01, a0, a1, d0, d1, 64'hC0C0_0000_0000_0000 + 64'(k),
                               1'b0, 1'b1, a0, d0);
            else
                vecs[4+k] = mk(2'b11, 2'b01, a0, a1, d0, d1, 64'hC0C0_0000_0000_0000 + 64'(k),
                               1'b1, 1'b0, a1, d1);
        end
        // Same master again right after its own grant: no starvation penalty.
        vecs[10] = mk(2'b10, 2'b00, 32'h0, 32'h2000_0FF0, 64'h0, 64'h0,
                      64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0, 32'h2000_0FF0, 64'h0);

        rst_n       = 1'b0;
        m_req_val   = 2'b00;
        m_req_cmd   = 2'b00;
        m_req_addr  = '0;
        m_req_data  = '0;
        m_resp_rdy  = 2'b00;
        s_req_rdy   = 1'b0;
        s_resp_val  = 1'b0;
        s_resp_cmd  = 1'b0;
        s_resp_addr = '0;
        s_resp_data = '0;
        #2;
        check("rst_req_rdy", 64'(m_req_rdy), 64'd0);
        check("rst_resp_val", 64'(m_resp_val), 64'd0);
        check("rst_s_req_val", 64'(s_req_val), 64'd0);
        check("rst_s_resp_rdy", 64'(s_resp_rdy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        check("rst_resp_data", m_resp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: m1 write, s_req_rdy low 5 cycles, then m_resp_rdy[1] low 3 cycles.
        begin
            int fires0;
            fires0 = s_fires;
            @(negedge clk);
            m_req_val  = 2'b10;
            m_req_cmd  = 2'b10;
            m_req_addr = {32'h5000_0040, 32'h0};
            m_req_data = {64'h0BAD_F00D_5A5A_A5A5, 64'h0};
            s_req_rdy  = 1'b0;
            m_resp_rdy = 2'b01;
            @(negedge clk);
            m_req_val = 2'b00;
            for (int i = 0; i < 5; i++) begin
                check($sformatf("bp_s_req_val_%0d", i), 64'(s_req_val), 64'd1);
                check($sformatf("bp_s_req_addr_%0d", i), 64'(s_req_addr), 64'h5000_0040);
                check($sformatf("bp_s_req_data_%0d", i), s_req_data, 64'h0BAD_F00D_5A5A_A5A5);
                check($sformatf("bp_s_req_cmd_%0d", i), 64'(s_req_cmd), 64'd1);
                check($sformatf("bp_s_resp_rdy_%0d", i), 64'(s_resp_rdy), 64'd0);
                s_resp_val = 1'b1;  // a response outside WAIT must be ignored
                @(negedge clk);
            end
            s_resp_val = 1'b0;
            s_req_rdy  = 1'b1;
            @(negedge clk);
            check("bp_wait_s_resp_rdy", 64'(s_resp_rdy), 64'd1);
            check("bp_wait_resp_val", 64'(m_resp_val), 64'd0);
            s_resp_val  = 1'b1;
            s_resp_cmd  = 1'b1;
            s_resp_addr = 32'h5000_0040;
            s_resp_data = 64'h0000_0000_0000_0001;
            @(negedge clk);
            s_resp_val  = 1'b0;
            s_resp_data = 64'hFFFF_FFFF_0000_0000;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_m_resp_val_%0d", i), 64'(m_resp_val), 64'h2);
                check($sformatf("bp_m_resp_addr_%0d", i), 64'(m_resp_addr), 64'h5000_0040);
                check($sformatf("bp_m_resp_data_%0d", i), m_resp_data, 64'h1);
                check($sformatf("bp_m_resp_cmd_%0d", i), 64'(m_resp_cmd), 64'd1);
                @(negedge clk);
            end
            check("bp_m_resp_val_last", 64'(m_resp_val), 64'h2);
            m_resp_rdy = 2'b10;
            @(negedge clk);
            check("bp_idle_busy", 64'(busy), 64'd0);
            check("bp_one_request", 64'(s_fires - fires0), 64'd1);
            m_resp_rdy = 2'b11;
        end

        // Reset while in WAIT: the transaction is dropped, then m1 is served normally.
        begin
            vec_t v;
            @(negedge clk);
            m_req_val  = 2'b01;
            m_req_cmd  = 2'b00;
            m_req_addr = {32'h0, 32'h6000_0000};
            m_req_data = '0;
            s_req_rdy  = 1'b1;
            @(negedge clk);
            m_req_val = 2'b00;
            @(negedge clk);
            check("rw_in_wait", 64'(s_resp_rdy), 64'd1);
            rst_n = 1'b0;
            #1;
            check("rw_busy", 64'(busy), 64'd0);
            check("rw_resp_val", 64'(m_resp_val), 64'd0);
            check("rw_s_resp_rdy", 64'(s_resp_rdy), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            check("rw_still_no_resp", 64'(m_resp_val), 64'd0);
            v = mk(2'b10, 2'b00, 32'h0, 32'h7000_0100, 64'h0, 64'h0,
                   64'h0F0F_0F0F_F0F0_F0F0, 1'b1, 1'b0, 32'h7000_0100, 64'h0);
            run_vec(v, "rw_after");
        end

`ifdef MMIO_ARB_TIMEOUT_EN
        // Silent downstream: all-ones response 16 cycles after entering ISSUE.
        begin
            @(negedge clk);
            m_req_val  = 2'b01;
            m_req_cmd  = 2'b01;
            m_req_addr = {32'h0, 32'h9000_0000};
            m_req_data = {64'h0, 64'h0000_0000_1234_0000};
            s_req_rdy  = 1'b1;
            m_resp_rdy = 2'b00;
            @(negedge clk);
            m_req_val = 2'b00;
            for (int i = 0; i < 15; i++) @(negedge clk);
            check("to_not_yet", 64'(m_resp_val), 64'd0);
            @(negedge clk);
            check("to_resp_val", 64'(m_resp_val), 64'h1);
            check("to_resp_data", m_resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
            check("to_resp_addr", 64'(m_resp_addr), 64'h9000_0000);
            check("to_resp_cmd", 64'(m_resp_cmd), 64'd1);
            check("to_flag", 64'(timeout_o), 64'd1);
            m_resp_rdy = 2'b01;
            @(negedge clk);
            check("to_idle", 64'(busy), 64'd0);
            check("to_sticky", 64'(timeout_o), 64'd1);
        end
`else
        check("no_timeout_flag", 64'(timeout_o), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
